uart_tx_ext: RTL and testbench
==============================

# uart_tx_ext

Parametrised UART transmitter, the next generation of the single-mode transmitter in the UART IP. It sits between the TX holding logic and the serial pin, and is clocked from the system clock with a per-sample `tick` from the shared baud generator. Over the previous block it adds:
- generic data width;
- run-time parity and stop-bit selection, latched per frame;
- a valid/ready input handshake that supports back-to-back frames;
- optional break generation.

## Interface
Parameters:
- `DATA_WD`, 8: data bits per frame, legal range 5..9.
- `OS_RATE`, 16: ticks per bit time, ≥ 2.
- `BREAK_BITS`, 13: bit times `tx` is held low during a break.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-`clk` pulse from the baud generator, `OS_RATE` pulses per bit.
- `din` input `DATA_WD`: frame payload.
- `din_valid` input 1: `din`, `parity_mode` and `stop2` are valid.
- `din_ready` output 1: the block accepts a frame this cycle.
- `parity_mode` input 2: 0 = none, 1 = odd, 2 = even, 3 = mark (parity bit always 1).
- `stop2` input 1: 0 = one stop bit, 1 = two stop bits.
- `break_req` input 1: request a line break. Only used when `UART_TX_BREAK_EN` is defined.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: a frame or break is in progress.
- `tx_done` output 1: one-cycle pulse at the end of each data frame.

## Operation
- All outputs are registered.
- Reset values: `tx` = 1, `tx_busy` = 0, `tx_done` = 0, `din_ready` = 1. State = IDLE, tick counter = 0, bit index = 0.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE, plus BREAK when the break feature is compiled in.

IDLE:
- `din_ready` = 1, `tx` = 1. `tick` is ignored and the tick counter is held at 0.
- Accept happens when `din_valid && din_ready`. On that edge, `din`, `parity_mode` and `stop2` are latched into shadow registers. Later changes on these inputs have no effect on the frame in flight.
- After accept: state = START, `tx` = 0, `tx_busy` = 1, `din_ready` = 0.

Bit timing:
- The tick counter increments only on `tick`.
- A bit ends on the edge where `tick` is high and the counter = `OS_RATE-1`. On that edge the counter wraps to 0 and the next bit value is driven onto `tx`.

Frame contents:
- DATA: `DATA_WD` bits sent LSB first. The bit index runs from 0 to `DATA_WD-1`.
- PARITY: entered only when the latched mode ≠ 0.
  - Odd: bit = ~^data.
  - Even: bit = ^data.
  - Mark: bit = 1.
- STOP: `tx` = 1 for 1 bit time, or 2 if the latched `stop2` = 1.

End of frame (the edge that ends the last stop bit):
- State = IDLE, `tx_done` = 1 for exactly one cycle, `tx_busy` = 0, `din_ready` = 1.
- A new frame can be accepted on the next edge, so back-to-back frames leave no idle gap beyond that single cycle.

## Timing
- Frame length in ticks = `OS_RATE` × (1 + `DATA_WD` + P + S), where P = 1 if parity is enabled (else 0) and S = 1 or 2.
- Accept to `tx` falling edge: 1 `clk`.
- Last stop tick to `tx_done`: 1 `clk`.
- Reset asserted mid-frame: on the next edge every output returns to its reset value. No `tx_done` pulse is produced and the latched data is discarded.
- `tick` coinciding with accept is not counted. The start bit lasts exactly `OS_RATE` ticks after accept.
- `din_valid` deasserted while `din_ready` = 0 has no effect. `din_valid` may be held high continuously.

## Configuration
`UART_TX_BREAK_EN` defined:
- In IDLE, `break_req` = 1 takes priority over `din_valid`, and `din_ready` reads 0 that cycle.
- The next edge enters BREAK: `tx` = 0, `tx_busy` = 1.
- After `BREAK_BITS` bit times, `tx` = 1 for one bit time (mark-after-break), then the block returns to IDLE.
- No `tx_done` pulse is produced for a break.

`UART_TX_BREAK_EN` not defined:
- The `break_req` port still exists but is ignored. The BREAK state and its counter are not synthesised.

## Test plan
- 0xA5, `parity_mode` = 0, `stop2` = 0, DATA_WD = 8, OS_RATE = 16: `tx` sequence is 0,1,0,1,0,0,1,0,1,1, 16 ticks each. `tx_done` pulses 1 cycle after tick 160. `tx_busy` is high throughout.
- 0xA5 with odd, then even, then mark parity, `stop2` = 1: parity bit = 1, 0, 1 respectively. Each frame lasts 192 ticks.
- `din_valid` held high with 0x00 then 0xFF: second accept occurs on the cycle after `tx_done`. No extra idle bit time between frames. `din` changed mid-frame does not alter the bits sent.
- `rst` pulsed at tick 70 of a frame: next edge gives `tx` = 1, `tx_busy` = 0, `din_ready` = 1, and no `tx_done`. A following frame is sent correctly.
- With `UART_TX_BREAK_EN`: `break_req` and `din_valid` together in IDLE. Expected: `tx` low for 208 ticks, high for 16 ticks, then IDLE, then the pending data frame is sent. Without the macro the same stimulus sends only the data frame.

Source files
------------

// File: rtl/uart_tx_ext.sv
// Parametrised UART transmitter: start, DATA_WD data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to build in line-break generation driven by break_req.
module uart_tx_ext #(
  parameter int DATA_WD    = 8,
  parameter int OS_RATE    = 16,
  parameter int BREAK_BITS = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [DATA_WD-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [1:0]         parity_mode,
  input  logic               stop2,
  input  logic               break_req,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int CNT_W = $clog2(OS_RATE);
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_WD-1:0] data_q;
  logic               par_en_q;
  logic               par_bit_q;
  logic               stop2_q;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic               ready_q;

  logic bit_end;
  logic accept;
  logic par_calc;

  assign bit_end = tick && (cnt_q == CNT_W'(OS_RATE - 1));

`ifdef UART_TX_BREAK_EN
  localparam int BRK_W = $clog2(BREAK_BITS + 1);
  logic [BRK_W-1:0] brk_q;
  // A pending break masks the handshake in the same cycle it is requested.
  assign din_ready = ready_q && !break_req;
`else
  logic unused_break;
  assign unused_break = break_req;
  assign din_ready    = ready_q;
`endif

  assign accept = din_valid && din_ready;

  always_comb begin
    par_calc = 1'b1;
    case (parity_mode)
      2'd1:    par_calc = ~^din;
      2'd2:    par_calc = ^din;
      default: par_calc = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // The tick that coincides with accept is not counted: the counter is held in IDLE.
      if (state_q == S_IDLE) cnt_q <= '0;
      else if (tick)         cnt_q <= bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          tx_q  <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_q <= S_BREAK;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            brk_q   <= '0;
          end else
`endif
          if (accept) begin
            state_q   <= S_START;
            data_q    <= din;
            par_en_q  <= (parity_mode != 2'd0);
            par_bit_q <= par_calc;
            stop2_q   <= stop2;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        S_START: if (bit_end) begin
          state_q <= S_DATA;
          tx_q    <= data_q[0];
        end
        S_DATA: if (bit_end) begin
          if (idx_q == IDX_W'(DATA_WD - 1)) begin
            idx_q   <= '0;
            state_q <= par_en_q ? S_PARITY : S_STOP;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_q  <= idx_q + 1'b1;
            data_q <= data_q >> 1;
            tx_q   <= data_q[1];
          end
        end
        S_PARITY: if (bit_end) begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
        end
        S_STOP: if (bit_end) begin
          if (stop2_q && (idx_q == '0)) begin
            idx_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        // BREAK_BITS low bit times followed by one mark-after-break bit time.
        S_BREAK: if (bit_end) begin
          brk_q <= brk_q + 1'b1;
          if (brk_q == BRK_W'(BREAK_BITS - 1)) tx_q <= 1'b1;
          if (brk_q == BRK_W'(BREAK_BITS)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ext.sv
// Self-checking bench for uart_tx_ext: expected line bits are queued when a frame is driven
// and popped tick by tick while the DUT shifts them out.
module tb_uart_tx_ext;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int BB = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [1:0]    parity_mode = 2'd0;
  logic          stop2 = 1'b0;
  logic          break_req = 1'b0;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  uart_tx_ext #(.DATA_WD(DW), .OS_RATE(OS), .BREAK_BITS(BB)) dut (
    .clk(clk), .rst(rst), .tick(tick), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .parity_mode(parity_mode), .stop2(stop2),
    .break_req(break_req), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // One tick every third clock, changed just after the edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      tick = (ph == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void push_frame(input logic [DW-1:0] d, input logic [1:0] m, input logic s2);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (m == 2'd1) exp_q.push_back(ones % 2 == 0);
    else if (m == 2'd2) exp_q.push_back(ones % 2 == 1);
    else if (m == 2'd3) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  // Returns at the negedge preceding the edge that consumes a tick.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called just after the accept edge; pops nbits and checks every tick plus the tx_done edge.
  task automatic check_frame(input int nbits, input string tag);
    bit ok;
    bit e;
    for (int b = 0; b < nbits; b++) begin
      e = exp_q.pop_front();
      for (int t = 0; t < OS; t++) begin
        wait_tick(ok);
        n_cmp++;
        if (!ok) begin
          n_err++;
          $display("FAIL %s tick timeout at bit %0d", tag, b);
          return;
        end
        if (tx !== e || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          n_err++;
          $display("FAIL %s bit %0d tick %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   tag, b, t, tx, tx_busy, tx_done, e);
        end
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0 || din_ready !== 1'b1 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL %s end: done=%b busy=%b ready=%b tx=%b, required 1 0 1 1",
               tag, tx_done, tx_busy, din_ready, tx);
    end
    $display("frame %s checked (%0d bits)", tag, nbits);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic s2, input bit hold);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send ready timeout: din_ready=%b required 1", din_ready);
    end
    din = d;
    parity_mode = m;
    stop2 = s2;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) din_valid = 1'b0;
    // Scramble the inputs: the frame in flight must use the latched copies.
    din = ~d;
    parity_mode = ~m;
    stop2 = ~s2;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1 || din_ready !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL accept 0x%02h: tx=%b busy=%b ready=%b done=%b, required 0 1 0 0",
               d, tx, tx_busy, din_ready, tx_done);
    end
    push_frame(d, m, s2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: tx=%b busy=%b done=%b ready=%b, required 1 0 0 1",
               tx, tx_busy, tx_done, din_ready);
    end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    send(8'hA5, 2'd0, 1'b0, 1'b0);
    check_frame(10, "basic_A5");
  endtask

  task automatic test_parity();
    for (int m = 1; m <= 3; m++) begin
      send(8'hA5, 2'(m), 1'b1, 1'b0);
      check_frame(12, $sformatf("parity_mode%0d", m));
    end
  endtask

  task automatic test_back_to_back();
    // Held valid; send() leaves din=0xFF, mode=3, stop2=1 presented for the next frame.
    send(8'h00, 2'd0, 1'b0, 1'b1);
    check_frame(10, "b2b_first");
    @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0 || din_ready !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b second accept: tx=%b ready=%b busy=%b done=%b, required 0 0 1 0",
               tx, din_ready, tx_busy, tx_done);
    end
    din_valid = 1'b0;
    din = 8'h12;
    push_frame(8'hFF, 2'd3, 1'b1);
    check_frame(12, "b2b_second");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad;
    send(8'h5A, 2'd2, 1'b0, 1'b0);
    exp_q.delete();
    for (int t = 0; t < 70; t++) wait_tick(ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || din_ready !== 1'b1 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
               tx, tx_busy, din_ready, tx_done);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_mid aftermath: line or done activity seen, required idle line and no tx_done");
    end
    $display("reset mid-frame checked");
    send(8'hC3, 2'd1, 1'b1, 1'b0);
    check_frame(12, "after_reset");
  endtask

  task automatic test_break();
    @(negedge clk);
    din = 8'h3C;
    parity_mode = 2'd0;
    stop2 = 1'b0;
    din_valid = 1'b1;
    break_req = 1'b1;
`ifdef UART_TX_BREAK_EN
    begin
      bit ok;
      bit e;
      #1;
      n_cmp++;
      if (din_ready !== 1'b0) begin
        n_err++;
        $display("FAIL break ready mask: din_ready=%b required 0", din_ready);
      end
      @(posedge clk);
      #1;
      break_req = 1'b0;
      n_cmp++;
      if (tx !== 1'b0 || tx_busy !== 1'b1 || din_ready !== 1'b0) begin
        n_err++;
        $display("FAIL break entry: tx=%b busy=%b ready=%b, required 0 1 0", tx, tx_busy, din_ready);
      end
      for (int t = 0; t < (BB + 1) * OS; t++) begin
        e = (t >= BB * OS);
        wait_tick(ok);
        n_cmp++;
        if (!ok || tx !== e || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
          n_err++;
          $display("FAIL break tick %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   t, tx, tx_busy, tx_done, e);
        end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || din_ready !== 1'b1 || tx_done !== 1'b0) begin
        n_err++;
        $display("FAIL break exit: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
                 tx, tx_busy, din_ready, tx_done);
      end
      $display("break checked");
    end
`endif
    @(posedge clk);
    #1;
    break_req = 1'b0;
    din_valid = 1'b0;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1 || din_ready !== 1'b0) begin
      n_err++;
      $display("FAIL break data accept: tx=%b busy=%b ready=%b, required 0 1 0", tx, tx_busy, din_ready);
    end
    push_frame(8'h3C, 2'd0, 1'b0);
    check_frame(10, "after_break");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
